// File: rtl/sabr_fx_pkg.sv
// Shared fixed-point constants, round-constant helper and sample type for the
// SABR product path.
package sabr_fx_pkg;

    localparam int PROD_W    = 79;
    localparam int FRAC_W    = 36;
    localparam int VAL_W     = 43;
    localparam int RND_MAX_W = 256;

    // Sample as it leaves the rounding adder: carry-extended product plus path tag.
    typedef struct packed {
        logic [PROD_W:0] data;
        logic            last;
    } sample_t;

    // Half-LSB of the retained result; zero when no fraction bits are removed.
    function automatic logic [RND_MAX_W-1:0] round_const(input int unsigned frac);
        logic [RND_MAX_W-1:0] r;
        r = '0;
        if (frac != 0) begin
            r = {{(RND_MAX_W-1){1'b0}}, 1'b1} << (frac - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/sabr_pipe_stage.sv
// Single valid/ready register slice; an empty or draining slice always accepts.
module sabr_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         adv;

    always_comb begin
        adv     = !valid_q || out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (adv) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/sabr_prod_rescale.sv
// Round-half-up rescale and saturate of the SABR multiplier product, two-stage
// valid/ready pipeline. Define SABR_PROD_STATS_EN to add the sat_count counter.
module sabr_prod_rescale
    import sabr_fx_pkg::*;
#(
    parameter int IN_WIDTH   = PROD_W,
    parameter int FRAC_SHIFT = FRAC_W,
    parameter int OUT_WIDTH  = VAL_W
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_prod,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 out_last
`ifdef SABR_PROD_STATS_EN
    ,
    output logic [31:0]          sat_count
`endif
);

    localparam int SUM_W = IN_WIDTH + 1;
    localparam int Q_W   = SUM_W - FRAC_SHIFT;
    localparam int S1_W  = Q_W + 1;
    localparam int S2_W  = OUT_WIDTH + 2;

    localparam logic [RND_MAX_W-1:0] RND_FULL = round_const(FRAC_SHIFT);
    localparam logic [SUM_W-1:0]     RND      = RND_FULL[SUM_W-1:0];

    if (FRAC_SHIFT < 0 || FRAC_SHIFT >= IN_WIDTH) begin : g_bad_frac
        $error("sabr_prod_rescale: FRAC_SHIFT out of range");
    end
    if (OUT_WIDTH < 1 || OUT_WIDTH > Q_W) begin : g_bad_out
        $error("sabr_prod_rescale: OUT_WIDTH too wide for the shifted product");
    end

    logic [Q_W-1:0]       s1_in_q;
    logic [S1_W-1:0]      s1_in_data;
    logic                 s1_in_ready;
    logic                 s1_valid;
    logic [S1_W-1:0]      s1_data;
    logic                 s2_in_ready;

    logic [Q_W-1:0]       s2_q;
    logic                 s2_last;
    logic                 s2_ovf;
    logic [OUT_WIDTH-1:0] s2_res;
    logic [S2_W-1:0]      s2_in_data;
    logic [S2_W-1:0]      s2_data;

    // Fraction bits below FRAC_SHIFT are never read after rounding, so only the
    // retained quotient (including the rounding carry) is registered in S1.
    always_comb begin
        s1_in_q    = Q_W'(({1'b0, in_prod} + RND) >> FRAC_SHIFT);
        s1_in_data = {s1_in_q, in_last};
    end

    sabr_pipe_stage #(.W(S1_W)) u_s1 (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (s1_in_ready),
        .in_data   (s1_in_data),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_data)
    );

    assign in_ready = s1_in_ready && !ap_rst;

    if (OUT_WIDTH < Q_W) begin : g_sat
        assign s2_ovf = |s2_q[Q_W-1:OUT_WIDTH];
    end else begin : g_nosat
        assign s2_ovf = 1'b0;
    end

    always_comb begin
        s2_q       = s1_data[S1_W-1:1];
        s2_last    = s1_data[0];
        s2_res     = s2_ovf ? {OUT_WIDTH{1'b1}} : s2_q[OUT_WIDTH-1:0];
        s2_in_data = {s2_res, s2_ovf, s2_last};
    end

    sabr_pipe_stage #(.W(S2_W)) u_s2 (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign out_data = s2_data[S2_W-1:2];
    assign out_sat  = s2_data[1];
    assign out_last = s2_data[0];

`ifdef SABR_PROD_STATS_EN
    logic [31:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (out_valid && out_ready && out_sat && (sat_cnt_q != 32'hFFFF_FFFF)) begin
            sat_cnt_d = sat_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sabr_prod_rescale.sv
// Directed bench for sabr_prod_rescale with a reference rounding model and an
// expected-output queue.
module tb_sabr_prod_rescale;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [78:0] in_prod;
    wire         in_ready;
    wire         out_valid;
    wire         out_sat;
    wire         out_last;
    wire  [42:0] out_data;
`ifdef SABR_PROD_STATS_EN
    wire  [31:0] sat_count;
`endif

    int total = 0;
    int bad   = 0;
    int exp_sat_cnt = 0;

    logic [78:0] vec_q[$];
    bit          last_q[$];
    logic [78:0] ones;
    logic [95:0] rr;

    always #5 ap_clk = ~ap_clk;

    sabr_prod_rescale dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_last  (out_last)
`ifdef SABR_PROD_STATS_EN
        ,
        .sat_count (sat_count)
`endif
    );

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // {sat, data}
    function automatic logic [43:0] ref_out(input logic [78:0] p);
        logic [79:0] s;
        logic [43:0] q;
        s = {1'b0, p} + (80'd1 << 35);
        q = s[79:36];
        if (q > 44'h7FF_FFFF_FFFF) ref_out = {1'b1, {43{1'b1}}};
        else                       ref_out = {1'b0, q[42:0]};
    endfunction

    task automatic check_sat_count(input string tag);
`ifdef SABR_PROD_STATS_EN
        chk({tag, " sat_count"}, sat_count, exp_sat_cnt);
`endif
    endtask

    task automatic run_stream(input int stall, input bit no_idle, input string tag);
        logic [44:0] expq[$];
        logic [44:0] e;
        logic [43:0] r;
        int n;
        int idx;
        int got;
        int occ;
        int cyc;
        n = vec_q.size();
        idx = 0; got = 0; occ = 0; cyc = 0;
        while (got < n && cyc < n + 50) begin
            in_valid  = (idx < n);
            in_prod   = (idx < n) ? vec_q[idx] : '0;
            in_last   = (idx < n) ? last_q[idx] : 1'b0;
            out_ready = (cyc >= stall);
            #1;
            chk({tag, " in_ready"}, in_ready, (occ < 2) || out_ready);
            if (no_idle && cyc < 2)
                chk({tag, " latency"}, out_valid, 1'b0);
            if (no_idle && cyc >= 2 && cyc < n + 2)
                chk({tag, " no_idle"}, out_valid, 1'b1);
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk({tag, " spurious"}, out_valid, 1'b0);
                end else begin
                    e = expq[0];
                    chk({tag, " data"}, out_data, e[42:0]);
                    chk({tag, " sat"},  out_sat,  e[43]);
                    chk({tag, " last"}, out_last, e[44]);
                    if (out_ready) begin
                        void'(expq.pop_front());
                        got++;
                        occ--;
                        if (e[43]) exp_sat_cnt++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                r = ref_out(vec_q[idx]);
                expq.push_back({in_last, r});
                idx++;
                occ++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, " drained"}, got, n);
        check_sat_count(tag);
        vec_q.delete();
        last_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        ones      = '1;
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst in_ready",  in_ready,  1'b0);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_data",  out_data,  43'd0);
        chk("rst out_sat",   out_sat,   1'b0);
        chk("rst out_last",  out_last,  1'b0);
        check_sat_count("rst");
        ap_rst = 1'b0;
        #1;
        chk("post_rst in_ready", in_ready, 1'b1);
        tick();

        // Rounding, single samples
        vec_q.push_back(79'd3 << 35);           last_q.push_back(1'b0);
        run_stream(0, 1'b1, "rnd_3x35");
        vec_q.push_back((79'd1 << 35) - 79'd1); last_q.push_back(1'b0);
        run_stream(0, 1'b1, "rnd_below_half");
        vec_q.push_back(79'd1 << 36);           last_q.push_back(1'b0);
        run_stream(0, 1'b1, "rnd_one");

        // Boundaries: zero, exact half, largest non-saturating, first saturating
        vec_q.push_back(79'd0);                          last_q.push_back(1'b0);
        vec_q.push_back(79'd1 << 35);                    last_q.push_back(1'b0);
        vec_q.push_back(ones - (79'd1 << 35));           last_q.push_back(1'b0);
        vec_q.push_back(ones - ((79'd1 << 35) - 79'd1)); last_q.push_back(1'b0);
        run_stream(0, 1'b1, "bound");

        // All-ones product carries into the top bit and saturates
        vec_q.push_back(ones); last_q.push_back(1'b0);
        run_stream(0, 1'b1, "sat_ones");

        // Back-pressure: 4 samples, downstream stalled 5 cycles
        for (int i = 1; i <= 4; i++) begin
            vec_q.push_back(79'(i) << 36);
            last_q.push_back(1'b0);
        end
        run_stream(5, 1'b0, "bp");

        // Last tag on third of three
        for (int i = 0; i < 3; i++) begin
            vec_q.push_back((79'(i) + 79'd7) << 36);
            last_q.push_back(i == 2);
        end
        run_stream(0, 1'b1, "last");

        // Reset with two samples in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_prod   = 79'd5 << 36;
        tick();
        in_prod   = 79'd6 << 36;
        tick();
        in_valid  = 1'b0;
        chk("mid_rst loaded", out_valid, 1'b1);
        ap_rst = 1'b1;
        #1;
        chk("mid_rst in_ready", in_ready, 1'b0);
        tick();
        chk("mid_rst out_valid", out_valid, 1'b0);
        chk("mid_rst out_data",  out_data,  43'd0);
        exp_sat_cnt = 0;
        check_sat_count("mid_rst");
        ap_rst    = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_rst in_ready_after", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst no_stale", out_valid, 1'b0);
        end

        // Continuous random stream with simultaneous accept and drain
        for (int i = 0; i < 100; i++) begin
            if (i % 20 == 7) begin
                vec_q.push_back(ones - 79'($urandom_range(0, 1000)));
            end else begin
                rr = {$urandom, $urandom, $urandom};
                rr = rr >> $urandom_range(0, 50);
                vec_q.push_back(rr[78:0]);
            end
            last_q.push_back(i == 99);
        end
        run_stream(0, 1'b1, "rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
